// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction queue between instruction memory and decode stage 1.
// Latency: a response pushed at edge k reaches the output register at edge k+1 at the earliest (2 edges memory-to-decode).
// Backpressure: block_fetch holds the head and emits NOPs; requests stop once queued + in-flight words reach DEPTH.
module fetch_queue #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 30,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [4:0]            OPCODE_NOP      = 5'b00000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         block_fetch,
  input  logic                         flush,
  input  logic [ADDR_WIDTH-1:0]        flush_pc,
  output logic                         mem_read,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ready,
  input  logic                         mem_valid,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic [DATA_WIDTH-1:0]        outbound_instruction,
  output logic [ADDR_WIDTH-1:0]        outbound_pc,
  output logic                         outbound_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = {OPCODE_NOP, {(DATA_WIDTH-5){1'b0}}};

  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         outstanding_next;
  logic [OW-1:0]         discard;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign mem_addr = fetch_pc;

  // Issue a request only while queue space covers every word already in flight
  always_comb begin
    mem_read = !flush
               && ((int'(count) + int'(outstanding)) < DEPTH)
               && (int'(outstanding) < MAX_OUTSTANDING);
  end

  // Handshake qualifiers; a flush blocks both the push of a late response and the pop
  always_comb begin
    accept = mem_read && mem_ready;
    push   = mem_valid && !flush && (discard == '0);
    pop    = !flush && !block_fetch && (count != '0);
  end

  // In-flight count after this edge's accept and response; seeds the discard count on flush
  always_comb begin
    outstanding_next = outstanding;
    if (accept && !mem_valid) begin
      outstanding_next = outstanding + OW'(1);
    end else if (!accept && mem_valid) begin
      outstanding_next = outstanding - OW'(1);
    end
  end

  // Fetch/response PCs, credit counters and queue pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (flush) begin
        // every word still owed by memory belongs to the abandoned path
        fetch_pc <= flush_pc;
        resp_pc  <= flush_pc;
        discard  <= outstanding_next;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
        end
        if (mem_valid) begin
          if (discard != '0) begin
            discard <= discard - OW'(1);
          end else begin
            resp_pc <= resp_pc + ADDR_WIDTH'(1);
          end
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  // Queue storage: response word tagged with the PC it was fetched from
  always_ff @(posedge clock) begin
    if (push) begin
      q_data[wr_ptr] <= mem_data;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

  // Output register: flush beats block_fetch beats pop; NOP whenever nothing real is issued
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outbound_instruction <= NOP_WORD;
      outbound_pc          <= '0;
      outbound_valid       <= 1'b0;
    end else if (flush) begin
      outbound_instruction <= NOP_WORD;
      outbound_valid       <= 1'b0;
    end else if (block_fetch) begin
      outbound_instruction <= NOP_WORD;
      outbound_valid       <= 1'b0;
    end else if (pop) begin
      outbound_instruction <= q_data[rd_ptr];
      outbound_pc          <= q_pc[rd_ptr];
      outbound_valid       <= 1'b1;
    end else begin
      outbound_instruction <= NOP_WORD;
      outbound_valid       <= 1'b0;
    end
  end

  // The credit rule makes a push into a full queue impossible
  always @(posedge clock) begin
    if (reset) begin
      assert (!(push && (count == CW'(DEPTH))));
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage: a prefetching instruction queue between instruction memory and decode.
- Issues in-order word fetches from a local PC, buffers responses with their PCs in a DEPTH-entry FIFO, and presents one instruction per cycle to stage 1.
- Inserts NOPs on block_fetch or when empty; flush redirects the PC and discards queued and in-flight words.

Parameters:
- DATA_WIDTH, 32, instruction word width; opcode occupies the top 5 bits.
- ADDR_WIDTH, 30, word address width.
- DEPTH, 4, queue entries; power of two, >=2.
- MAX_OUTSTANDING, 2, maximum accepted but unanswered memory requests; >=1.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- block_fetch  in  1  downstream hazard; emit NOP, hold queue head.
- flush  in  1  redirect request (taken branch/jump).
- flush_pc  in  ADDR_WIDTH  new fetch address when flush=1.
- mem_read  out  1  fetch request, combinational.
- mem_addr  out  ADDR_WIDTH  request word address (current fetch PC).
- mem_ready  in  1  memory accepts request this cycle.
- mem_valid  in  1  response valid; responses return in order, latency >=1.
- mem_data  in  DATA_WIDTH  response word.
- outbound_instruction  out  DATA_WIDTH  instruction to stage 1.
- outbound_pc  out  ADDR_WIDTH  address of outbound_instruction.
- outbound_valid  out  1  1 = real instruction, 0 = inserted NOP.
- count  out  clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- NOP word = {OPCODE_NOP, (DATA_WIDTH-5)'b0}.
- Reset (reset=0, async):
  - outbound_instruction=NOP, outbound_pc=0, outbound_valid=0, count=0.
  - fetch_pc=resp_pc=RESET_PC; outstanding=0, discard=0.
- Request issue:
  - mem_read = !flush && (count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - Accepted when mem_read && mem_ready: fetch_pc+1 (wraps modulo 2^ADDR_WIDTH), outstanding+1.
- Response handling (mem_valid=1):
  - Always decrements outstanding.
  - If discard>0: word dropped, discard-1.
  - Otherwise {mem_data, resp_pc} written at tail, resp_pc+1.
  - Credit rule guarantees a push never finds the queue full; a push when full is an assertion failure.
- Output register, priority flush > block_fetch > pop, per edge:
  - flush=1: queue emptied (count=0); output NOP/valid=0.
    - fetch_pc<=flush_pc, resp_pc<=flush_pc.
    - discard <= outstanding_next, the outstanding count after this edge's accept/response. A response arriving in the flush cycle is itself dropped.
  - block_fetch=1: output NOP, valid=0, outbound_pc unchanged; head not popped; pushes continue.
  - Otherwise, count>0: head popped into the outputs, valid=1.
  - Otherwise, count=0: NOP, valid=0.
- Latency:
  - A word pushed at edge k is poppable at edge k+1 earliest; no bypass.
  - Minimum memory-to-decode latency is 2 edges.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- count reports registered occupancy, excluding the output register.
- Reset mid-operation clears everything immediately. Responses to pre-reset requests must not be delivered after reset; the memory model is reset together with this block.

Test Plan:
- Reset and fill:
  - Stimulus: reset low, release; mem_ready=1, 1-cycle memory returning data=0x1000_0000+addr.
  - Required: mem_addr 0,1,2,...; outbound 0x10000000 (pc 0, valid=1) on the third edge, then one per cycle in order.
  - Required: count never exceeds 4; outstanding never exceeds 2.
- Block:
  - Stimulus: block_fetch=1 for 3 cycles with queue at 4.
  - Required: three NOPs with valid=0 and outbound_pc unchanged; mem_read=0 while full.
  - Required: after release, the next word has pc exactly +1 from the last one issued before the block; no loss or duplication.
- Flush with in-flight:
  - Stimulus: 3-cycle memory latency, 2 outstanding; flush=1, flush_pc=0x100.
  - Required: both stale responses dropped; first valid output has pc 0x100.
  - Required: mem_read=0 in the flush cycle; the next request address is 0x100.
- Flush in the same cycle as mem_valid and block_fetch:
  - Required: flush wins; the response is dropped; output is NOP.
- PC wrap:
  - Stimulus: ADDR_WIDTH=4, flush_pc=0xE.
  - Required: outbound pcs 0xE, 0xF, 0x0, 0x1.
- Reset mid-stream:
  - Stimulus: assert reset with count=3.
  - Required: outputs return to NOP/valid=0/count=0 asynchronously, before the next clock edge.
